// File: rtl/efuse_prog_ctrl.sv
// rtl/efuse_prog_ctrl.sv - eFuse word programming sequencer (one fuse at a time)
// Optional: EFUSE_SKIP_ZERO_EN skips SETUP/STROBE/HOLD for zero bits.
module efuse_prog_ctrl #(
  parameter int NW   = 64,
  parameter int WSEL = 256 / NW,
  localparam int SW  = (WSEL > 1) ? $clog2(WSEL) : 1,
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    rg_efuse_tpgm,
  input  logic [SW-1:0] write_sel,
  input  logic [NW-1:0] write_data,
  input  logic          write_start,
  output logic          write_done,
  output logic          busy_write,
  output logic          efuse_pgmen_o,
  output logic          efuse_rden_o,
  output logic          efuse_aen_o,
  output logic [7:0]    efuse_addr_o
);

  if (NW * WSEL != 256) begin : g_bad_geometry
    $error("efuse_prog_ctrl: NW*WSEL must equal 256");
  end
  if ((NW & (NW - 1)) != 0) begin : g_bad_nw
    $error("efuse_prog_ctrl: NW must be a power of two");
  end

  typedef enum logic [2:0] {
    IDLE, SCAN, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NW-1:0] data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [9:0]    tpgm_q, tpgm_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          pgmen_q, pgmen_d;
  logic          aen_q, aen_d;
  logic [7:0]    addr_q, addr_d;
  logic [9:0]    t_val;
  logic          last_bit;
  logic          pgm_win;

  assign t_val    = (tpgm_q == 10'd0) ? 10'd1 : tpgm_q;
  assign last_bit = (idx_q == IW'(NW - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sel_d   = sel_q;
    tpgm_d  = tpgm_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (write_start) begin
          data_d  = write_data;
          sel_d   = write_sel;
          tpgm_d  = rg_efuse_tpgm;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
`ifdef EFUSE_SKIP_ZERO_EN
        if (data_q[idx_q]) begin
          state_d = SETUP;
        end else if (last_bit) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`else
        state_d = SETUP;
`endif
      end
      SETUP: begin
        cnt_d   = t_val;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q <= 10'd1) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      HOLD: begin
        if (last_bit) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    pgm_win = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    pgmen_d = pgm_win;
    aen_d   = (state_d == STROBE) && data_d[idx_d];
    addr_d  = pgm_win ? 8'({sel_d, idx_d}) : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      tpgm_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pgmen_q <= 1'b0;
      aen_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      tpgm_q  <= tpgm_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pgmen_q <= pgmen_d;
      aen_q   <= aen_d;
      addr_q  <= addr_d;
    end
  end

  assign write_done    = done_q;
  assign busy_write    = busy_q;
  assign efuse_pgmen_o = pgmen_q;
  assign efuse_aen_o   = aen_q;
  assign efuse_addr_o  = addr_q;
  assign efuse_rden_o  = 1'b0;

endmodule

// File: tb/tb_efuse_prog_ctrl.sv
// tb/tb_efuse_prog_ctrl.sv - directed self-checking bench for efuse_prog_ctrl
// Expected values follow EFUSE_SKIP_ZERO_EN when the bench is built with it.
module tb_efuse_prog_ctrl;

`ifdef EFUSE_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rg_efuse_tpgm = '0;
  logic [1:0]  write_sel = '0;
  logic [63:0] write_data = '0;
  logic        write_start = 1'b0;
  logic        write_done, busy_write, efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
  logic [7:0]  efuse_addr_o;

  int errors = 0;
  int checks = 0;

  int busy_tot = 0, pgmen_tot = 0, aen_tot = 0, done_tot = 0, inv_err = 0;
  logic aen_prev = 1'b0;
  logic [7:0] strobe_q[$];

  efuse_prog_ctrl #(.NW(64)) dut (
    .clk(clk), .rst(rst), .rg_efuse_tpgm(rg_efuse_tpgm),
    .write_sel(write_sel), .write_data(write_data), .write_start(write_start),
    .write_done(write_done), .busy_write(busy_write),
    .efuse_pgmen_o(efuse_pgmen_o), .efuse_rden_o(efuse_rden_o),
    .efuse_aen_o(efuse_aen_o), .efuse_addr_o(efuse_addr_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy_write)    busy_tot++;
    if (efuse_pgmen_o) pgmen_tot++;
    if (efuse_aen_o)   aen_tot++;
    if (write_done)    done_tot++;
    if (efuse_aen_o && !aen_prev) strobe_q.push_back(efuse_addr_o);
    aen_prev = efuse_aen_o;
    if (efuse_aen_o && !efuse_pgmen_o) inv_err++;
    if (!efuse_pgmen_o && efuse_addr_o != 8'd0) inv_err++;
    if (efuse_rden_o !== 1'b0) inv_err++;
    if (write_done && !busy_write) inv_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] sel, input logic [63:0] data,
                     input logic [9:0] tpgm, input int exp_busy, input int exp_pgmen,
                     input int exp_aen, input int nstr, input logic [31:0] addrs,
                     input bit restart);
    int b0, p0, a0, d0, s0;
    bit seen;
    logic [7:0] exp_a;
    @(negedge clk);
    #1;
    b0 = busy_tot; p0 = pgmen_tot; a0 = aen_tot; d0 = done_tot; s0 = strobe_q.size();
    write_sel = sel; write_data = data; rg_efuse_tpgm = tpgm; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0; write_sel = ~sel; write_data = ~data; rg_efuse_tpgm = ~tpgm;
    if (restart) begin
      repeat (10) @(negedge clk);
      write_sel = sel ^ 2'b01; write_data = 64'hFF; write_start = 1'b1;
      @(negedge clk);
      write_start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (write_done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    // A start presented during the DONE cycle must not launch a new sequence.
    write_start = 1'b1; write_data = 64'hFFFF; write_sel = 2'd3;
    @(negedge clk);
    write_start = 1'b0;
    check({tag, " idle_after_done"}, 32'(busy_write), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check({tag, " stay_idle"}, 32'(busy_write), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_tot - b0), 32'(exp_busy));
    check({tag, " pgmen_cycles"}, 32'(pgmen_tot - p0), 32'(exp_pgmen));
    check({tag, " aen_cycles"}, 32'(aen_tot - a0), 32'(exp_aen));
    check({tag, " done_pulses"}, 32'(done_tot - d0), 32'd1);
    check({tag, " strobes"}, 32'(strobe_q.size() - s0), 32'(nstr));
    for (int i = 0; i < nstr; i++) begin
      exp_a = addrs[8*i +: 8];
      if (s0 + i < strobe_q.size())
        check({tag, " strobe_addr"}, 32'(strobe_q[s0 + i]), 32'(exp_a));
    end
  endtask

  initial begin
    bit seen;
    int d0;
    #2;
    check("reset_busy", 32'(busy_write), 32'd0);
    check("reset_done", 32'(write_done), 32'd0);
    check("reset_pgmen", 32'(efuse_pgmen_o), 32'd0);
    check("reset_aen", 32'(efuse_aen_o), 32'd0);
    check("reset_addr", 32'(efuse_addr_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run("t1_f0", 2'd0, 64'hF0, 10'd0, SKIP ? 77 : 257, SKIP ? 12 : 192, 4, 4,
        {8'h07, 8'h06, 8'h05, 8'h04}, 1'b0);
    run("t2_12", 2'd1, 64'h12, 10'd0, SKIP ? 71 : 257, SKIP ? 6 : 192, 2, 2,
        {16'h0, 8'h44, 8'h41}, 1'b0);
    run("t3_tp5", 2'd3, 64'h1, 10'd5, SKIP ? 72 : 513, SKIP ? 7 : 448, 5, 1,
        {24'h0, 8'hC0}, 1'b0);
    run("t4_zero", 2'd2, 64'h0, 10'd3, SKIP ? 65 : 385, SKIP ? 0 : 320, 0, 0,
        32'h0, 1'b0);
    run("t5_restart", 2'd2, 64'h3, 10'd0, SKIP ? 71 : 257, SKIP ? 6 : 192, 2, 2,
        {16'h0, 8'h81, 8'h80}, 1'b1);

    // Abort in the middle of a long strobe with an asynchronous reset.
    @(negedge clk);
    write_sel = 2'd0; write_data = 64'h1; rg_efuse_tpgm = 10'd10; write_start = 1'b1;
    @(negedge clk);
    write_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (efuse_aen_o) seen = 1'b1;
    end
    check("t6_reached_strobe", 32'(seen), 32'd1);
    d0 = done_tot;
    #1 rst = 1'b1;
    #1;
    check("t6_async_pgmen", 32'(efuse_pgmen_o), 32'd0);
    check("t6_async_aen", 32'(efuse_aen_o), 32'd0);
    check("t6_async_addr", 32'(efuse_addr_o), 32'd0);
    check("t6_async_busy", 32'(busy_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("t6_no_done", 32'(done_tot - d0), 32'd0);
    check("t6_idle", 32'(busy_write), 32'd0);

    run("t7_after_rst", 2'd0, 64'hF0, 10'd0, SKIP ? 77 : 257, SKIP ? 12 : 192, 4, 4,
        {8'h07, 8'h06, 8'h05, 8'h04}, 1'b0);

    check("invariants", 32'(inv_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/efuse_prog_ctrl.md
Name: efuse_prog_ctrl

Overview:
- Programming sequencer for a 256-bit one-time-programmable eFuse macro organised as WSEL words of NW bits.
- On a start pulse, it latches one word and its word index, then blows every '1' bit one fuse at a time.
- It drives the macro's program-enable, address-strobe and address pins with the strobe width set by a register.
- It sits between the eFuse register block and the eFuse hard macro, beside the read sequencer.

Parameters:
- NW, 64, word width in bits; power of two.
- WSEL, 256/NW, number of words; NW*WSEL must equal 256 (elaboration error otherwise).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rg_efuse_tpgm  input  10  strobe width in clk cycles; 0 is treated as 1.
- write_sel  input  $clog2(WSEL)  word index to program.
- write_data  input  NW  word value; bit=1 means blow that fuse.
- write_start  input  1  start request, sampled only in IDLE.
- write_done  output  1  one-cycle pulse when the sequence completes.
- busy_write  output  1  high while the sequence runs.
- efuse_pgmen_o  output  1  program enable to the macro.
- efuse_rden_o  output  1  read enable; tied 0.
- efuse_aen_o  output  1  address/program strobe.
- efuse_addr_o  output  8  fuse bit address.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - A reset mid-sequence aborts immediately; no write_done is issued.
- Definitions:
  - T = max(tpgm_latched, 1).
  - addr = {sel_latched, idx}, zero-extended to 8 bits.
  - idx is an internal $clog2(NW)-bit bit counter.
- IDLE:
  - Outputs 0.
  - When write_start=1, latch write_data, write_sel and rg_efuse_tpgm, clear idx, and go to SCAN.
  - Input changes after the latch have no effect.
- SCAN (1 cycle):
  - busy_write=1.
  - If data_latched[idx]=1, go to SETUP.
  - Otherwise, go to DONE if idx=NW-1, else idx++ and stay in SCAN.
- SETUP (1 cycle): efuse_pgmen_o=1, efuse_addr_o=addr, efuse_aen_o=0.
- STROBE (T cycles): efuse_pgmen_o=1, efuse_aen_o=1, address held. A down-counter is loaded with T.
- HOLD (1 cycle): efuse_pgmen_o=1, efuse_aen_o=0, address held. Then go to DONE if idx=NW-1, else idx++ and go to SCAN.
- DONE (1 cycle): write_done=1 and busy_write=1, then go to IDLE.
- busy_write is 1 in every state except IDLE; it rises the cycle after write_start is sampled.
- Outside SETUP/STROBE/HOLD: efuse_addr_o=0 and efuse_pgmen_o=0.
- efuse_aen_o is only ever high while efuse_pgmen_o is high.
- write_start is ignored while busy_write=1, including the DONE cycle.
- efuse_rden_o is constant 0.
- Latency (feature enabled): NW SCAN cycles + ones*(T+2) + 1 DONE cycle.

Optional Feature:
- Macro: EFUSE_SKIP_ZERO_EN.
- Defined: behaviour as above. Zero bits cost one SCAN cycle and raise no pgmen.
- Undefined: every bit, including zero bits, runs SETUP/STROBE/HOLD, giving constant latency NW*(T+3)+1 cycles.
  - efuse_pgmen_o and address toggle for every bit.
  - efuse_aen_o is asserted only when the bit is 1.

Test Plan:
- NW=64, sel=0, data=0xF0, tpgm=0 (feature on) → 4 strobes at addr 4,5,6,7, each aen 1 cycle, pgmen 3 cycles per bit; write_done after 64+4*3+1=77 busy cycles.
- sel=1, data=0x12, tpgm=0 → strobes only at addr 0x41 and 0x44; no pgmen for other bits.
- sel=3, data=0x1, tpgm=5 → one strobe at addr 0xC0, aen high exactly 5 cycles, pgmen high 7 cycles.
- data=0 → no pgmen/aen ever; write_done after 65 busy cycles; feature off → 64*4+1=257 cycles, aen never high.
- write_start pulsed again mid-sequence with different sel/data → ignored; original addresses programmed.
- rst asserted during STROBE → all outputs 0 same cycle (async); no write_done; a new start after release runs normally.
